core_c1_exu_wbck: RTL and testbench
===================================

Name: core_c1_exu_wbck

Overview:
- Write-back stage directly downstream of the EXU ALU.
- Merges the single-cycle ALU result (alu_rd_data/alu_rd_valid plus destination index) with load results returning from the LSU.
- Drives the registered write port of the integer register file.
- Owns a one-entry ALU skid buffer so the ALU is only stalled on a back-to-back LSU/ALU collision, and reports RAW hazards against the buffered entry to the issue logic.

Parameters:
- XLEN, 32, data width of all result and register-file data paths.
- IDXW, 5, register index width.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-high; all state cleared while high.
- alu_rd_valid  in  1  ALU has a result this cycle (from the ALU stage).
- alu_rd_data  in  XLEN  ALU result.
- alu_rd_idx  in  IDXW  ALU destination register.
- alu_wbck_ready  out  1  ALU result accepted this cycle. Combinational. Low means the EXU must hold the instruction.
- lsu_rd_valid  in  1  single-cycle load-data pulse; always accepted.
- lsu_rd_data  in  XLEN  load data, already sign/zero extended.
- lsu_rd_idx  in  IDXW  load destination register.
- hz_rs1_idx  in  IDXW  issue-stage rs1 index to check.
- hz_rs2_idx  in  IDXW  issue-stage rs2 index to check.
- hz_stall  out  1  combinational RAW hazard against the skid buffer.
- wb_rf_wen  out  1  register-file write enable (registered).
- wb_rf_idx  out  IDXW  register-file write index (registered).
- wb_rf_data  out  XLEN  register-file write data (registered).
- wbck_cnt  out  32  count of results written back, including x0 targets.

Behaviour:
- Reset: buf_valid=0, buf_idx=0, buf_data=0, wb_rf_wen=0, wb_rf_idx=0, wb_rf_data=0, wbck_cnt=0. Asserting rst mid-operation discards any buffered ALU result; no write is issued for it.
- Source selection each cycle uses the fixed priority LSU > buffer > live ALU:
  - lsu_rd_valid=1: LSU result is written. An accepted live ALU result goes into the buffer. An existing buffer entry holds.
  - lsu_rd_valid=0, buf_valid=1: buffer is written. An accepted live ALU result refills the buffer in the same cycle; otherwise buf_valid clears.
  - lsu_rd_valid=0, buf_valid=0, alu_rd_valid=1: live ALU result is written directly. Buffer stays empty.
- alu_wbck_ready = ~(buf_valid & lsu_rd_valid).
  - Stall only when the buffer is full and the LSU wins the port.
  - The ALU result is not captured on a stall cycle.
  - ALU inputs must remain stable until ready is seen.
- Write port timing:
  - Selected source appears on wb_rf_* one cycle after selection.
  - wb_rf_wen is high for exactly one cycle per selected result, except as below.
- x0 handling:
  - Idx 0 results are consumed normally.
  - wb_rf_wen=0 for them; wb_rf_idx and wb_rf_data still update.
  - wbck_cnt still increments.
- Idle cycles (no source selected): wb_rf_wen=0; wb_rf_idx and wb_rf_data hold their previous values.
- wbck_cnt:
  - Increments by 1 each cycle a source is selected; at most one per cycle.
  - Wraps from 0xFFFF_FFFF to 0.
- hz_stall = buf_valid & (buf_idx!=0) & ((buf_idx==hz_rs1_idx) | (buf_idx==hz_rs2_idx)).
  - Hazards against the wb_rf_* register are resolved by register-file write-through, not by this block.
- Ordering: at most one result per destination is reordered, and only an ALU result behind an older load. The buffer entry is always written before any later live ALU result.
- Arithmetic: pure data movement; no width conversion.

Test Plan:
- ALU only: alu_rd_valid=1, idx=5, data=0x0000_1234 for one cycle.
  - Next cycle: wb_rf_wen=1, idx=5, data=0x1234.
  - alu_wbck_ready=1 throughout; wbck_cnt=1.
- Collision: lsu (idx=3, 0xDEAD_BEEF) and alu (idx=4, 0x11) in the same cycle.
  - Cycle+1: write x3=0xDEADBEEF. Cycle+2: write x4=0x11.
  - alu_wbck_ready=1; hz_stall=1 for hz_rs1_idx=4 during cycle+1.
- Stall: buffer full (x4), then lsu (x6) and a new alu (x7) together.
  - alu_wbck_ready=0 that cycle.
  - Writes occur in order x6, x4, x7 on three consecutive cycles.
- x0 target: alu idx=0, data=0xFFFF_FFFF.
  - wb_rf_wen stays 0; wb_rf_data=0xFFFF_FFFF next cycle; wbck_cnt increments.
  - hz_stall=0 with hz_rs1_idx=0.
- Reset mid-operation: assert rst asynchronously while buf_valid=1.
  - All outputs go to 0 immediately without waiting for a clock edge; buffered result is never written.
  - After release, the first ALU result writes normally.
- Counter wrap: preload via 2^32-1 accepted results (or force wbck_cnt=0xFFFF_FFFF), then one more result → wbck_cnt=0.

Source files
------------

// File: rtl/core_c1_exu_wbck.sv
// Write-back stage behind the EXU ALU: merges ALU and LSU results onto the
// single registered integer register-file write port. A one-entry skid
// buffer absorbs an ALU result that loses the port to a load, so the ALU
// only stalls when a load arrives while that buffer is already occupied.
module core_c1_exu_wbck #(
  parameter int XLEN = 32,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_rd_valid,
  input  logic [XLEN-1:0] alu_rd_data,
  input  logic [IDXW-1:0] alu_rd_idx,
  output logic            alu_wbck_ready,
  input  logic            lsu_rd_valid,
  input  logic [XLEN-1:0] lsu_rd_data,
  input  logic [IDXW-1:0] lsu_rd_idx,
  input  logic [IDXW-1:0] hz_rs1_idx,
  input  logic [IDXW-1:0] hz_rs2_idx,
  output logic            hz_stall,
  output logic            wb_rf_wen,
  output logic [IDXW-1:0] wb_rf_idx,
  output logic [XLEN-1:0] wb_rf_data,
  output logic [31:0]     wbck_cnt
);

  logic            buf_valid;
  logic [IDXW-1:0] buf_idx;
  logic [XLEN-1:0] buf_data;

  logic            alu_accept;
  logic            buf_load;
  logic            buf_clear;
  logic            sel_any;
  logic [IDXW-1:0] sel_idx;
  logic [XLEN-1:0] sel_data;

  // The ALU only has to wait when the buffer is occupied and a load
  // takes the port, because then there is nowhere to park its result.
  assign alu_wbck_ready = ~(buf_valid & lsu_rd_valid);
  assign alu_accept     = alu_rd_valid & alu_wbck_ready;

  // An accepted ALU result is parked whenever something older (a load or
  // the current buffer entry) owns the port; the buffer drains when it
  // wins the port and nothing new arrives to replace it.
  assign buf_load  = alu_accept & (lsu_rd_valid | buf_valid);
  assign buf_clear = ~lsu_rd_valid & buf_valid & ~alu_rd_valid;

  // Issue must wait on a source that is still sitting in the buffer;
  // x0 never creates a dependency.
  assign hz_stall = buf_valid & (buf_idx != '0) &
                    ((buf_idx == hz_rs1_idx) | (buf_idx == hz_rs2_idx));

  // Pick the write-port source with priority load, then buffer, then live ALU.
  always_comb begin
    sel_any  = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    if (lsu_rd_valid) begin
      sel_any  = 1'b1;
      sel_idx  = lsu_rd_idx;
      sel_data = lsu_rd_data;
    end else if (buf_valid) begin
      sel_any  = 1'b1;
      sel_idx  = buf_idx;
      sel_data = buf_data;
    end else if (alu_rd_valid) begin
      sel_any  = 1'b1;
      sel_idx  = alu_rd_idx;
      sel_data = alu_rd_data;
    end
  end

  // Skid buffer register; reset throws away any parked result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
      buf_idx   <= alu_rd_idx;
      buf_data  <= alu_rd_data;
    end else if (buf_clear) begin
      buf_valid <= 1'b0;
    end
  end

  // Registered write port: x0 results update index/data but never enable
  // the write; idle cycles keep the last index/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rf_wen  <= 1'b0;
      wb_rf_idx  <= '0;
      wb_rf_data <= '0;
    end else begin
      wb_rf_wen <= sel_any & (sel_idx != '0);
      if (sel_any) begin
        wb_rf_idx  <= sel_idx;
        wb_rf_data <= sel_data;
      end
    end
  end

  // Count every consumed result, including x0 targets; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbck_cnt <= 32'd0;
    end else if (sel_any) begin
      wbck_cnt <= wbck_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_core_c1_exu_wbck.sv
// Bench for core_c1_exu_wbck: directed scenarios with literal expectations
// followed by random traffic, all checked against a queue-based model of
// the write-back ordering rules.
module tb_core_c1_exu_wbck;

  logic        clk;
  logic        rst;
  logic        alu_rd_valid;
  logic [31:0] alu_rd_data;
  logic [4:0]  alu_rd_idx;
  logic        alu_wbck_ready;
  logic        lsu_rd_valid;
  logic [31:0] lsu_rd_data;
  logic [4:0]  lsu_rd_idx;
  logic [4:0]  hz_rs1_idx;
  logic [4:0]  hz_rs2_idx;
  logic        hz_stall;
  logic        wb_rf_wen;
  logic [4:0]  wb_rf_idx;
  logic [31:0] wb_rf_data;
  logic [31:0] wbck_cnt;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } result_t;

  // Model: results accepted but not yet written, oldest first.
  result_t     pend_q[$];
  logic        m_wen;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic [31:0] m_cnt;
  logic        m_ready;

  int vectors;
  int miscompares;

  core_c1_exu_wbck #(.XLEN(32), .IDXW(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_rd_valid   (alu_rd_valid),
    .alu_rd_data    (alu_rd_data),
    .alu_rd_idx     (alu_rd_idx),
    .alu_wbck_ready (alu_wbck_ready),
    .lsu_rd_valid   (lsu_rd_valid),
    .lsu_rd_data    (lsu_rd_data),
    .lsu_rd_idx     (lsu_rd_idx),
    .hz_rs1_idx     (hz_rs1_idx),
    .hz_rs2_idx     (hz_rs2_idx),
    .hz_stall       (hz_stall),
    .wb_rf_wen      (wb_rf_wen),
    .wb_rf_idx      (wb_rf_idx),
    .wb_rf_data     (wb_rf_data),
    .wbck_cnt       (wbck_cnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic av, input logic [31:0] ad, input logic [4:0] ai,
                               input logic lv, input logic [31:0] ld, input logic [4:0] li,
                               input logic [4:0] r1, input logic [4:0] r2);
    alu_rd_valid = av;
    alu_rd_data  = ad;
    alu_rd_idx   = ai;
    lsu_rd_valid = lv;
    lsu_rd_data  = ld;
    lsu_rd_idx   = li;
    hz_rs1_idx   = r1;
    hz_rs2_idx   = r2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    pend_q.delete();
    m_wen  = 1'b0;
    m_idx  = '0;
    m_data = '0;
    m_cnt  = '0;
  endtask

  // Combinational outputs as the model sees the current inputs.
  task automatic checkComb();
    logic exp_hz;
    m_ready = !(pend_q.size() != 0 && lsu_rd_valid);
    exp_hz  = pend_q.size() != 0 && pend_q[0].idx != 0 &&
              (pend_q[0].idx == hz_rs1_idx || pend_q[0].idx == hz_rs2_idx);
    checkOutput("alu_wbck_ready", {31'd0, alu_wbck_ready}, {31'd0, m_ready});
    checkOutput("hz_stall", {31'd0, hz_stall}, {31'd0, exp_hz});
  endtask

  // One clock: check combinational outputs, advance the model through the
  // edge, then check the registered outputs just after it.
  task automatic stepCycle();
    bit      got;
    result_t w;
    result_t a;
    #1;
    checkComb();
    a.idx  = alu_rd_idx;
    a.data = alu_rd_data;
    got    = 1'b0;
    w      = '0;
    if (lsu_rd_valid) begin
      got    = 1'b1;
      w.idx  = lsu_rd_idx;
      w.data = lsu_rd_data;
      if (alu_rd_valid && m_ready) pend_q.push_back(a);
    end else if (pend_q.size() != 0) begin
      got = 1'b1;
      w   = pend_q.pop_front();
      if (alu_rd_valid) pend_q.push_back(a);
    end else if (alu_rd_valid) begin
      got = 1'b1;
      w   = a;
    end
    @(posedge clk);
    #1;
    m_wen = got && (w.idx != 0);
    if (got) begin
      m_idx  = w.idx;
      m_data = w.data;
      m_cnt  = m_cnt + 1;
    end
    checkOutput("wb_rf_wen", {31'd0, wb_rf_wen}, {31'd0, m_wen});
    checkOutput("wb_rf_idx", {27'd0, wb_rf_idx}, {27'd0, m_idx});
    checkOutput("wb_rf_data", wb_rf_data, m_data);
    checkOutput("wbck_cnt", wbck_cnt, m_cnt);
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    logic        hold;
    logic        av;
    logic [31:0] ad;
    logic [4:0]  ai;
    vectors     = 0;
    miscompares = 0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #12;
    checkOutput("reset_wen", {31'd0, wb_rf_wen}, 32'd0);
    checkOutput("reset_cnt", wbck_cnt, 32'd0);
    checkOutput("reset_data", wb_rf_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU only.
    applyStimulus(1, 32'h0000_1234, 5, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("alu_only_wen", {31'd0, wb_rf_wen}, 32'd1);
    checkOutput("alu_only_idx", {27'd0, wb_rf_idx}, 32'd5);
    checkOutput("alu_only_data", wb_rf_data, 32'h1234);
    checkOutput("alu_only_cnt", wbck_cnt, 32'd1);

    // Collision: load wins, ALU result parked then written.
    applyStimulus(1, 32'h11, 4, 1, 32'hDEAD_BEEF, 3, 0, 0);
    stepCycle();
    checkOutput("coll_idx1", {27'd0, wb_rf_idx}, 32'd3);
    checkOutput("coll_data1", wb_rf_data, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0);
    #1;
    checkOutput("coll_hz", {31'd0, hz_stall}, 32'd1);
    stepCycle();
    checkOutput("coll_idx2", {27'd0, wb_rf_idx}, 32'd4);
    checkOutput("coll_data2", wb_rf_data, 32'h11);
    checkOutput("coll_wen2", {31'd0, wb_rf_wen}, 32'd1);

    // Stall: buffer holds x4 when load x6 and ALU x7 arrive together.
    applyStimulus(1, 32'h44, 4, 1, 32'h33, 3, 0, 0);
    stepCycle();
    applyStimulus(1, 32'h77, 7, 1, 32'h66, 6, 0, 0);
    #1;
    checkOutput("stall_ready", {31'd0, alu_wbck_ready}, 32'd0);
    stepCycle();
    checkOutput("stall_w1", {27'd0, wb_rf_idx}, 32'd6);
    applyStimulus(1, 32'h77, 7, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("stall_w2", {27'd0, wb_rf_idx}, 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("stall_w3", {27'd0, wb_rf_idx}, 32'd7);
    checkOutput("stall_w3_data", wb_rf_data, 32'h77);

    // x0 target written directly.
    applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("x0_wen", {31'd0, wb_rf_wen}, 32'd0);
    checkOutput("x0_data", wb_rf_data, 32'hFFFF_FFFF);
    // x0 parked in the buffer never raises a hazard.
    applyStimulus(1, 32'h5A5A, 0, 1, 32'h22, 2, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("x0_hz", {31'd0, hz_stall}, 32'd0);
    stepCycle();
    checkOutput("x0_buf_wen", {31'd0, wb_rf_wen}, 32'd0);
    checkOutput("x0_buf_data", wb_rf_data, 32'h5A5A);

    // Reset mid-operation with a parked result.
    applyStimulus(1, 32'hBAD0, 9, 1, 32'h88, 8, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_wen", {31'd0, wb_rf_wen}, 32'd0);
    checkOutput("rst_async_idx", {27'd0, wb_rf_idx}, 32'd0);
    checkOutput("rst_async_data", wb_rf_data, 32'd0);
    checkOutput("rst_async_cnt", wbck_cnt, 32'd0);
    checkOutput("rst_async_hz", {31'd0, hz_stall}, 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("rst_no_stale", {31'd0, wb_rf_wen}, 32'd0);
    applyStimulus(1, 32'hCAFE, 10, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("rst_after_idx", {27'd0, wb_rf_idx}, 32'd10);
    checkOutput("rst_after_cnt", wbck_cnt, 32'd1);

    // Counter wrap.
    force dut.wbck_cnt = 32'hFFFF_FFFF;
    release dut.wbck_cnt;
    m_cnt = 32'hFFFF_FFFF;
    applyStimulus(1, 32'h1, 1, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("cnt_wrap", wbck_cnt, 32'd0);

    // Randomized traffic; a stalled ALU result is held until accepted.
    hold = 1'b0;
    av   = 1'b0;
    ad   = '0;
    ai   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        av = ($urandom_range(0, 3) != 0);
        ad = $urandom;
        ai = 5'($urandom_range(0, 7));
      end
      applyStimulus(av, ad, ai, ($urandom_range(0, 2) == 0), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
      stepCycle();
      hold = av && !m_ready;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
